// File: rtl/mod_divisor_quinto.sv
// mod_divisor_quinto: sequential signed divide-by-5 (9-bit dividend, 6-bit quotient); define MOD_DIVISOR_QUINTO_SAT_EN to saturate F on overflow
module mod_divisor_quinto (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [8:0] A,
  output logic [5:0] F,
  output logic [2:0] R,
  output logic       OF,
  output logic       BUSY,
  output logic       DONE
);
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;
  state_t      state_q, state_d;
  logic [8:0]  dvd_q, dvd_d;
  logic [8:0]  quo_q, quo_d;
  logic [2:0]  rem_q, rem_d;
  logic        neg_q, neg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  f_q, f_d;
  logic [2:0]  r_q, r_d;
  logic        of_q, of_d;
  logic [8:0]  abs_a;
  logic [3:0]  rem_sh;
  logic        ge5;
  logic [2:0]  rem_nx;
  logic        of_fix;
  logic [5:0]  q_wrap;
  logic [5:0]  f_fix;
  // Two's complement magnitude; 9 bits unsigned holds |-256| = 256
  assign abs_a  = A[8] ? ~A + 9'd1 : A;
  assign rem_sh = {rem_q, dvd_q[8]};
  assign ge5    = rem_sh >= 4'd5;
  assign rem_nx = ge5 ? 3'(rem_sh - 4'd5) : rem_sh[2:0];
  // Negative quotients may reach -32, positive ones only 31
  assign of_fix = neg_q ? (quo_q > 9'd32) : (quo_q > 9'd31);
  assign q_wrap = neg_q ? ~quo_q[5:0] + 6'd1 : quo_q[5:0];
`ifdef MOD_DIVISOR_QUINTO_SAT_EN
  assign f_fix  = of_fix ? (neg_q ? 6'b100000 : 6'b011111) : q_wrap;
`else
  assign f_fix  = q_wrap;
`endif
  assign F    = f_q;
  assign R    = r_q;
  assign OF   = of_q;
  assign BUSY = (state_q == S_DIV) || (state_q == S_FIX);
  assign DONE = state_q == S_DONE;
  // Next-state and datapath: accept, nine restoring iterations, sign fix-up
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    r_d     = r_q;
    of_d    = of_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = START ? S_DIV : S_IDLE;
        if (START) begin
          dvd_d = abs_a;
          neg_d = A[8];
          quo_d = '0;
          rem_d = '0;
          cnt_d = '0;
        end
      end
      S_DIV: begin
        dvd_d   = {dvd_q[7:0], 1'b0};
        quo_d   = {quo_q[7:0], ge5};
        rem_d   = rem_nx;
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd8) ? S_FIX : S_DIV;
      end
      S_FIX: begin
        f_d     = f_fix;
        r_d     = rem_q;
        of_d    = of_fix;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // State and result registers; reset aborts any division in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      f_q     <= '0;
      r_q     <= '0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      r_q     <= r_d;
      of_q    <= of_d;
    end
  end
endmodule
